// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives a req/ack instruction-memory port and
// buffers fetched words with their PCs in a small FIFO for the decoder.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_adel,
  input  logic        out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {FETCH, DROP, HALT} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     pc_reg, pc_next;
  logic [31:0]     addr_reg;
  logic            req_reg;
  logic            halt_pend_reg;
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg, count_next;

  logic [31:0]     instr_mem [DEPTH];
  logic [31:0]     pc_mem    [DEPTH];
  logic            adel_mem  [DEPTH];

  logic            outstanding_next;
  logic            push_fetch, push_adel, push, pop, issue;

  always_comb begin
    outstanding_next = req_reg && !imem_ack;
    pop        = (count_reg != '0) && out_ready && !redirect;
    push_fetch = !redirect && (state_reg == FETCH) && req_reg && imem_ack;
    push_adel  = !redirect && (state_reg == HALT) && halt_pend_reg;
    push       = push_fetch || push_adel;
    count_next = redirect ? '0 : count_reg + CW'(push) - CW'(pop);
    pc_next    = redirect ? redirect_pc : (push_fetch ? pc_reg + 32'd4 : pc_reg);

    // A stale request must finish before the new target is classified.
    state_next = state_reg;
    if (redirect)
      state_next = outstanding_next ? DROP :
                   ((redirect_pc[1:0] != 2'b00) ? HALT : FETCH);
    else if ((state_reg == DROP) && imem_ack)
      state_next = (pc_reg[1:0] != 2'b00) ? HALT : FETCH;

    // Reserve a FIFO slot for every request in flight so a push never overflows.
    issue = (state_next == FETCH) && !outstanding_next && (count_next < CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= FETCH;
      pc_reg        <= RESET_PC;
      req_reg       <= 1'b0;
      addr_reg      <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      halt_pend_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      count_reg <= count_next;

      if (redirect) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end

      if (outstanding_next) begin
        req_reg <= 1'b1;
      end else if (issue) begin
        req_reg  <= 1'b1;
        addr_reg <= pc_next;
      end else begin
        req_reg <= 1'b0;
      end

      if (state_next != HALT)
        halt_pend_reg <= 1'b0;
      else if (redirect || (state_reg != HALT))
        halt_pend_reg <= 1'b1;
      else if (push_adel)
        halt_pend_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= push_adel ? 32'h0 : imem_rdata;
      pc_mem[wr_ptr_reg]    <= pc_reg;
      adel_mem[wr_ptr_reg]  <= push_adel;
    end
  end

  assign imem_req  = req_reg;
  assign imem_addr = addr_reg;
  assign out_valid = (count_reg != '0);
  assign out_instr = out_valid ? instr_mem[rd_ptr_reg] : 32'h0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr_reg]    : 32'h0;
  assign out_adel  = out_valid && adel_mem[rd_ptr_reg];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a memory model, a fetch-stream
// reference model that queues expected entries, and an output monitor.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_adel;
  logic        out_ready = 1'b1;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_adel(out_adel), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } ent_t;

  ent_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  logic [31:0] last_pop_pc = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Memory: acks after a per-request latency drawn from [lat_min, lat_max].
  int lat_min = 0, lat_max = 0, cur_lat = 0, wcnt = 0;
  always begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      imem_ack = 1'b0;
      wcnt = 0;
    end else begin
      #1;
      imem_ack = 1'b0;
      if (imem_req) begin
        if (wcnt >= cur_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wcnt       = 0;
          cur_lat    = $urandom_range(lat_max, lat_min);
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Reference model of the fetch stream.
  logic [31:0] m_pc = RESET_PC;
  bit          m_drop = 0, m_halt = 0, halt_now = 0, prev_pend = 0;
  logic [31:0] prev_addr = 32'h0;

  task automatic enter_target();
    if (m_pc[1:0] != 2'b00) begin
      m_halt = 1;
      exp_q.push_back('{pc: m_pc, instr: 32'h0, adel: 1'b1});
    end else begin
      m_halt = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      m_pc = RESET_PC;
      m_drop = 0;
      m_halt = 0;
      prev_pend = 0;
    end else begin
      halt_now = m_halt;
      if (prev_pend) begin
        chk("req_held", 32'(imem_req), 32'd1);
        chk("addr_held", imem_addr, prev_addr);
      end
      if (halt_now) chk("halt_no_req", 32'(imem_req), 32'd0);
      if (redirect) begin
        exp_q.delete();
        m_pc = redirect_pc;
        if (imem_req && !imem_ack) begin
          m_drop = 1;
          m_halt = 0;
        end else begin
          m_drop = 0;
          enter_target();
        end
      end else if (imem_req && imem_ack) begin
        if (m_drop) begin
          m_drop = 0;
          enter_target();
        end else begin
          chk("fetch_addr", imem_addr, m_pc);
          exp_q.push_back('{pc: m_pc, instr: mem_word(m_pc), adel: 1'b0});
          m_pc = m_pc + 32'd4;
          chk("fifo_bound", 32'(exp_q.size() <= DEPTH), 32'd1);
        end
      end
      prev_pend = imem_req && !imem_ack;
      prev_addr = imem_addr;
    end
  end

  // Monitor: every accepted head must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got pc %h with nothing expected", out_pc);
      end else begin
        ent_t e;
        e = exp_q.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_instr", out_instr, e.instr);
        chk("out_adel", 32'(out_adel), 32'(e.adel));
      end
      pops++;
      last_pop_pc = out_pc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_lat(input int lo, input int hi);
    lat_min = lo;
    lat_max = hi;
    cur_lat = lo;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect = 1'b1;
    redirect_pc = pc;
    tick();
    redirect = 1'b0;
  endtask

  task automatic wait_pop_pc(input string name, input logic [31:0] pc);
    int p0;
    bit seen;
    p0 = pops;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (pops != p0) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: got no output within 20 cycles expected pc %h", name, pc);
    end else begin
      chk(name, last_pop_pc, pc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1);
  end

  initial begin
    int p0;
    bit hit;

    tick();
    tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_adel", 32'(out_adel), 32'd0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);

    reset_n = 1'b1;
    tick();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, RESET_PC);

    // Zero-wait memory: one instruction per cycle.
    repeat (5) tick();
    p0 = pops;
    repeat (20) tick();
    chk("throughput", 32'(pops - p0), 32'd20);

    // Back-pressure fills the FIFO and stops requests.
    out_ready = 1'b0;
    repeat (10) tick();
    chk("full_count", 32'(exp_q.size()), 32'(DEPTH));
    chk("full_req_low", 32'(imem_req), 32'd0);
    out_ready = 1'b1;
    repeat (10) tick();

    // Redirect in the second wait cycle of a 3-cycle memory.
    set_lat(3, 3);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      if (imem_req && !imem_ack && wcnt == 1) hit = 1;
    end
    chk("wait_found", 32'(hit), 32'd1);
    tick();
    do_redirect(32'h8000_0100);
    wait_pop_pc("redir_wait_pc", 32'h8000_0100);
    repeat (5) tick();

    // Redirect coinciding with an ack while two entries are buffered.
    set_lat(0, 0);
    out_ready = 1'b0;
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      tick();
      if (exp_q.size() == 2 && imem_req && imem_ack) hit = 1;
    end
    chk("two_buffered", 32'(hit), 32'd1);
    do_redirect(32'h8000_0400);
    out_ready = 1'b1;
    wait_pop_pc("redir_ack_pc", 32'h8000_0400);
    repeat (3) tick();

    // Misaligned target: single AdEL entry then no fetching.
    do_redirect(32'h8000_0102);
    wait_pop_pc("adel_pc", 32'h8000_0102);
    repeat (5) tick();
    chk("halt_req_low", 32'(imem_req), 32'd0);
    chk("halt_empty", 32'(out_valid), 32'd0);
    do_redirect(32'h8000_0200);
    wait_pop_pc("resume_pc", 32'h8000_0200);

    // PC wrap at the top of the address space.
    do_redirect(32'hFFFF_FFF0);
    wait_pop_pc("wrap_start", 32'hFFFF_FFF0);
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick();
      if (last_pop_pc == 32'h0) hit = 1;
    end
    chk("wrap_zero", 32'(hit), 32'd1);

    // Random traffic.
    set_lat(0, 3);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      out_ready = ($urandom_range(0, 3) != 0);
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[31:8] = 24'hFFFFFF;
      a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      redirect = ($urandom_range(0, 19) == 0);
      redirect_pc = a;
      tick();
    end
    redirect = 1'b0;
    out_ready = 1'b1;
    do_redirect(32'h0000_0001);
    repeat (20) tick();
    chk("drained", 32'(exp_q.size()), 32'd0);
    chk("final_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset while a request is pending.
    set_lat(3, 3);
    do_redirect(32'h0000_1000);
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick();
      if (imem_req && !imem_ack) hit = 1;
    end
    chk("req_pending", 32'(hit), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_adel", 32'(out_adel), 32'd0);
    chk("arst_instr", out_instr, 32'h0);
    chk("arst_pc", out_pc, 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_req", 32'(imem_req), 32'd1);
    chk("post_rst_addr", imem_addr, RESET_PC);
    wait_pop_pc("post_rst_pc", RESET_PC);
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
